// File: rtl/clksel_sequencer_pkg.sv
// Shared constants for the CPU clock-source hand-over sequencer.
// Holds the state encoding, the divide-select encoding and the default parameter values.
package clksel_sequencer_pkg;

  localparam logic [2:0] ST_LS_RUN     = 3'd0;
  localparam logic [2:0] ST_LS_STOP    = 3'd1;
  localparam logic [2:0] ST_DEAD_TO_HS = 3'd2;
  localparam logic [2:0] ST_HS_RUN     = 3'd3;
  localparam logic [2:0] ST_HS_STOP    = 3'd4;
  localparam logic [2:0] ST_DEAD_TO_LS = 3'd5;
  localparam logic [2:0] ST_WAIT_LS    = 3'd6;

  // The hs_phase period is 2*2^sel hsclk cycles.
  localparam logic [1:0] DIV_2  = 2'b00;
  localparam logic [1:0] DIV_4  = 2'b01;
  localparam logic [1:0] DIV_8  = 2'b10;
  localparam logic [1:0] DIV_16 = 2'b11;

  localparam int DEF_SYNC_STAGES = 2;
  localparam int DEF_DEAD_CYCLES = 2;
  localparam int DEF_MIN_DWELL   = 4;

  function automatic logic is_hs_clocked(input logic [2:0] st);
    return (st == ST_HS_RUN) || (st == ST_HS_STOP);
  endfunction

  function automatic logic is_run_state(input logic [2:0] st);
    return (st == ST_LS_RUN) || (st == ST_HS_RUN);
  endfunction

endpackage

// File: rtl/clksel_sequencer_sync_edge_det.sv
// Multi-flop synchroniser for an asynchronous level, with rise/fall pulses
// derived from the last synchronised stage and its one-cycle-delayed copy.
module clksel_sequencer_sync_edge_det #(
  parameter int STAGES = 2
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic d_i,
  output logic sync_o,
  output logic rise_o,
  output logic fall_o
);

  logic [STAGES-1:0] chain_q;
  logic              prev_q;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      chain_q <= '0;
      prev_q  <= 1'b0;
    end else begin
      chain_q <= {chain_q[STAGES-2:0], d_i};
      prev_q  <= chain_q[STAGES-1];
    end
  end

  assign sync_o = chain_q[STAGES-1];
  assign rise_o = ~prev_q & chain_q[STAGES-1];
  assign fall_o = prev_q & ~chain_q[STAGES-1];

endmodule

// File: rtl/clksel_sequencer.sv
// Glitch-free CPU clock hand-over between phi0 (low speed) and divided hsclk (high speed).
// Gates only close while their source is low and both stay shut for DEAD_CYCLES between sources.
module clksel_sequencer
  import clksel_sequencer_pkg::*;
#(
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int DEAD_CYCLES = DEF_DEAD_CYCLES,
  parameter int MIN_DWELL   = DEF_MIN_DWELL
) (
  input  logic       hsclk,
  input  logic       reset,
  input  logic       lsclk_in,
  input  logic       hs_req,
  input  logic       enable,
  input  logic [1:0] hsclk_div_sel,
  output logic       ls_gate_en,
  output logic       hs_gate_en,
  output logic       hs_phase,
  output logic       hs_active,
  output logic       busy,
  output logic [2:0] state_dbg_o,
  output logic [1:0] ls_edge_dbg_o
);

  localparam logic [2:0] DEAD_LAST  = 3'(DEAD_CYCLES - 1);
  localparam logic [3:0] DWELL_LOAD = 4'(MIN_DWELL);

  logic [2:0] state_q, state_d;
  logic [3:0] div_cnt_q, div_cnt_d;
  logic [1:0] div_sel_q, div_sel_d;
  logic [3:0] dwell_q, dwell_d;
  logic [2:0] dead_q, dead_d;
  logic       ls_gate_q, hs_gate_q, hs_phase_q, hs_active_q, busy_q;

  logic       ls_s, ls_rise, ls_fall;
  logic       want_hs, dwell_done, phase_fall, in_dead_d;
  logic [3:0] div_cnt_inc;

  clksel_sequencer_sync_edge_det #(
    .STAGES (SYNC_STAGES)
  ) u_ls_sync (
    .clk_i   (hsclk),
    .reset_i (reset),
    .d_i     (lsclk_in),
    .sync_o  (ls_s),
    .rise_o  (ls_rise),
    .fall_o  (ls_fall)
  );

  assign want_hs     = hs_req & enable;
  assign dwell_done  = (dwell_q == 4'd0);
  assign div_cnt_inc = div_cnt_q + 4'd1;
  // hs_phase is currently high and drops on this edge: the HS source is about to go low.
  assign phase_fall  = hs_phase_q & ~div_cnt_inc[div_sel_q];

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_LS_RUN:     if (want_hs && dwell_done) state_d = ST_LS_STOP;
      ST_LS_STOP: begin
        if (!want_hs)     state_d = ST_LS_RUN;
        else if (ls_fall) state_d = ST_DEAD_TO_HS;
      end
      ST_DEAD_TO_HS: if (dead_q == DEAD_LAST) state_d = ST_HS_RUN;
      ST_HS_RUN:     if (!want_hs && dwell_done) state_d = ST_HS_STOP;
      ST_HS_STOP:    if (phase_fall) state_d = ST_DEAD_TO_LS;
      ST_DEAD_TO_LS: if (dead_q == DEAD_LAST) state_d = ST_WAIT_LS;
      ST_WAIT_LS:    if (ls_fall) state_d = ST_LS_RUN;
      default:       state_d = ST_LS_RUN;
    endcase
  end

  always_comb begin
    in_dead_d = (state_d == ST_DEAD_TO_HS) || (state_d == ST_DEAD_TO_LS);
    dead_d    = (in_dead_d && state_d == state_q) ? dead_q + 3'd1 : 3'd0;

    // An abort from LS_STOP back to LS_RUN does not restart the dwell window.
    dwell_d = (dwell_q != 4'd0) ? dwell_q - 4'd1 : 4'd0;
    if ((state_d == ST_LS_RUN && state_q != ST_LS_RUN && state_q != ST_LS_STOP) ||
        (state_d == ST_HS_RUN && state_q != ST_HS_RUN))
      dwell_d = DWELL_LOAD;

    div_cnt_d = div_cnt_q;
    div_sel_d = div_sel_q;
    if (state_d == ST_HS_RUN && state_q != ST_HS_RUN) begin
      div_cnt_d = 4'd0;
      div_sel_d = hsclk_div_sel;
    end else if (is_hs_clocked(state_q)) begin
      div_cnt_d = div_cnt_inc;
    end
  end

  always_ff @(posedge hsclk) begin
    if (reset) begin
      state_q     <= ST_LS_RUN;
      div_cnt_q   <= 4'd0;
      div_sel_q   <= DIV_2;
      dwell_q     <= 4'd0;
      dead_q      <= 3'd0;
      ls_gate_q   <= 1'b1;
      hs_gate_q   <= 1'b0;
      hs_phase_q  <= 1'b0;
      hs_active_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      div_cnt_q   <= div_cnt_d;
      div_sel_q   <= div_sel_d;
      dwell_q     <= dwell_d;
      dead_q      <= dead_d;
      ls_gate_q   <= (state_d == ST_LS_RUN) || (state_d == ST_LS_STOP);
      hs_gate_q   <= is_hs_clocked(state_d);
      hs_phase_q  <= is_hs_clocked(state_d) & div_cnt_d[div_sel_d];
      hs_active_q <= is_hs_clocked(state_d) || (state_d == ST_DEAD_TO_LS);
      busy_q      <= ~is_run_state(state_d);
    end
  end

  assign ls_gate_en    = ls_gate_q;
  assign hs_gate_en    = hs_gate_q;
  assign hs_phase      = hs_phase_q;
  assign hs_active     = hs_active_q;
  assign busy          = busy_q;
  assign state_dbg_o   = state_q;
  assign ls_edge_dbg_o = {ls_rise, ls_fall};

endmodule
